// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator for the decode stage.
// Each accepted instruction word is decoded combinationally. Its
// sign-extended immediate, format code and illegal-encoding flag are then
// captured into a main output register (M). A skid register (K) absorbs one
// extra entry, so in_ready is driven purely from state.
//
// Ports:
//   clk, rst (async, active-high), flush (sync, drops both entries)
//   in_valid/in_ready/in_inst/in_tag     upstream handshake + payload
//   out_valid/out_ready                  downstream handshake
//   out_imm (XLEN), out_fmt (0=N 1=I 2=S 3=B 4=U 5=J 6=Z), out_err,
//   out_inst, out_tag                    registered result + passthrough
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter bit EN_ZICSR = 1'b1,
  parameter int TAG_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_err,
  output logic [31:0]      out_inst,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_N = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_Z = 3'd6;

  // All formats are first assembled as a signed 32-bit value; widening that
  // to XLEN is then a plain sign extension from bit 31 (this also gives the
  // RV64 LUI/AUIPC behaviour).
  function automatic logic [XLEN-1:0] sext_to_xlen(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  // ---- p0: combinational decode of the offered word ----
  logic signed [31:0] raw_p0;
  logic [XLEN-1:0]    dec_imm_p0;
  logic [2:0]         dec_fmt_p0;
  logic               dec_err_p0;

  always_comb begin
    raw_p0     = '0;
    dec_fmt_p0 = FMT_N;
    dec_err_p0 = 1'b0;
    case (in_inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec_fmt_p0 = FMT_I;
        raw_p0     = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_fmt_p0 = FMT_I;
          raw_p0     = {{20{in_inst[31]}}, in_inst[31:20]};
        end else begin
          dec_err_p0 = 1'b1;
        end
      end
      7'b0100011: begin
        dec_fmt_p0 = FMT_S;
        raw_p0     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b1100011: begin
        dec_fmt_p0 = FMT_B;
        raw_p0     = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                      in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b0010111, 7'b0110111: begin
        dec_fmt_p0 = FMT_U;
        raw_p0     = {in_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt_p0 = FMT_J;
        raw_p0     = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                      in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b0110011, 7'b0001111: begin
        dec_fmt_p0 = FMT_N;
      end
      7'b0111011: begin
        dec_err_p0 = (XLEN != 64);
      end
      7'b1110011: begin
        // CSR immediate forms (funct3[2]=1) carry a 5-bit zero-extended zimm.
        if (EN_ZICSR && in_inst[14]) begin
          dec_fmt_p0 = FMT_Z;
          raw_p0     = {27'b0, in_inst[19:15]};
        end
      end
      default: begin
        dec_err_p0 = 1'b1;
      end
    endcase
    dec_imm_p0 = sext_to_xlen(raw_p0);
  end

  // ---- p1: main register M and skid register K ----
  logic             vld_p1, vld_sk_p1;
  logic [XLEN-1:0]  imm_p1, imm_sk_p1;
  logic [2:0]       fmt_p1, fmt_sk_p1;
  logic             err_p1, err_sk_p1;
  logic [31:0]      inst_p1, inst_sk_p1;
  logic [TAG_W-1:0] tag_p1, tag_sk_p1;

  logic accept, m_free;

  assign in_ready = !vld_sk_p1;
  assign accept   = in_valid && in_ready;
  // M can be (re)loaded when it is empty or being consumed this cycle.
  assign m_free   = !vld_p1 || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_sk_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      vld_sk_p1 <= 1'b0;
    end else if (m_free) begin
      if (vld_sk_p1) begin
        // in_ready is low while K holds data, so no acceptance here.
        vld_p1    <= 1'b1;
        vld_sk_p1 <= 1'b0;
      end else begin
        vld_p1    <= accept;
      end
    end else if (accept) begin
      vld_sk_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (m_free) begin
      if (vld_sk_p1) begin
        imm_p1  <= imm_sk_p1;
        fmt_p1  <= fmt_sk_p1;
        err_p1  <= err_sk_p1;
        inst_p1 <= inst_sk_p1;
        tag_p1  <= tag_sk_p1;
      end else if (accept) begin
        imm_p1  <= dec_imm_p0;
        fmt_p1  <= dec_fmt_p0;
        err_p1  <= dec_err_p0;
        inst_p1 <= in_inst;
        tag_p1  <= in_tag;
      end
    end else if (accept) begin
      imm_sk_p1  <= dec_imm_p0;
      fmt_sk_p1  <= dec_fmt_p0;
      err_sk_p1  <= dec_err_p0;
      inst_sk_p1 <= in_inst;
      tag_sk_p1  <= in_tag;
    end
  end

  // Data registers are not reset; gating the decoded fields with the valid
  // bit gives defined zero values whenever M is empty.
  assign out_valid = vld_p1;
  assign out_imm   = vld_p1 ? imm_p1 : '0;
  assign out_fmt   = vld_p1 ? fmt_p1 : FMT_N;
  assign out_err   = vld_p1 && err_p1;
  assign out_inst  = inst_p1;
  assign out_tag   = tag_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe. Three instances (RV32+Zicsr,
// RV64+Zicsr, RV64 without Zicsr) share one stimulus stream and are checked
// against a FIFO scoreboard plus an arithmetic decode reference.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_tag;

  logic        rdy_a, rdy_b, rdy_c, vld_a, vld_b, vld_c;
  logic [31:0] imm_a;
  logic [63:0] imm_b, imm_c;
  logic [2:0]  fmt_a, fmt_b, fmt_c;
  logic        err_a, err_b, err_c;
  logic [31:0] inst_a, inst_b, inst_c, tag_a, tag_b, tag_c;

  imm_gen_pipe #(.XLEN(32), .EN_ZICSR(1'b1), .TAG_W(32)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(vld_a), .out_ready(out_ready),
    .out_imm(imm_a), .out_fmt(fmt_a), .out_err(err_a), .out_inst(inst_a), .out_tag(tag_a));
  imm_gen_pipe #(.XLEN(64), .EN_ZICSR(1'b1), .TAG_W(32)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(vld_b), .out_ready(out_ready),
    .out_imm(imm_b), .out_fmt(fmt_b), .out_err(err_b), .out_inst(inst_b), .out_tag(tag_b));
  imm_gen_pipe #(.XLEN(64), .EN_ZICSR(1'b0), .TAG_W(32)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(vld_c), .out_ready(out_ready),
    .out_imm(imm_c), .out_fmt(fmt_c), .out_err(err_c), .out_inst(inst_c), .out_tag(tag_c));

  logic        o_rdy [3], o_vld [3], o_err [3];
  logic [63:0] o_imm [3];
  logic [2:0]  o_fmt [3];
  logic [31:0] o_inst [3], o_tag [3];
  always_comb begin
    o_rdy[0] = rdy_a; o_rdy[1] = rdy_b; o_rdy[2] = rdy_c;
    o_vld[0] = vld_a; o_vld[1] = vld_b; o_vld[2] = vld_c;
    o_err[0] = err_a; o_err[1] = err_b; o_err[2] = err_c;
    o_imm[0] = {32'b0, imm_a}; o_imm[1] = imm_b; o_imm[2] = imm_c;
    o_fmt[0] = fmt_a; o_fmt[1] = fmt_b; o_fmt[2] = fmt_c;
    o_inst[0] = inst_a; o_inst[1] = inst_b; o_inst[2] = inst_c;
    o_tag[0] = tag_a; o_tag[1] = tag_b; o_tag[2] = tag_c;
  end

  int xl [3] = '{32, 64, 64};
  bit zc [3] = '{1'b1, 1'b1, 1'b0};
  logic [6:0] ops [14] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h17,
                           7'h37, 7'h6F, 7'h33, 7'h0F, 7'h3B, 7'h73, 7'h7F};

  typedef struct { logic [31:0] inst; logic [31:0] tag; } ent_t;
  ent_t q [$];
  int   checks = 0;
  int   failures = 0;
  bit   last_acc = 1'b0;
  logic [31:0] tagctr = 32'h1000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode: value of each immediate field read as a signed number,
  // reduced modulo 2^32 for RV32.
  function automatic void ref_dec(input logic [31:0] i, input int xlen, input bit zic,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic err);
    longint v;
    v = 0; fmt = 3'd0; err = 1'b0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: begin fmt = 3'd1; v = longint'($signed(i[31:20])); end
      7'h1B: if (xlen == 64) begin fmt = 3'd1; v = longint'($signed(i[31:20])); end
             else err = 1'b1;
      7'h23: begin fmt = 3'd2; v = longint'($signed({i[31:25], i[11:7]})); end
      7'h63: begin fmt = 3'd3; v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'h17, 7'h37: begin fmt = 3'd4; v = longint'($signed({i[31:12], 12'b0})); end
      7'h6F: begin fmt = 3'd5; v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      7'h33, 7'h0F: ;
      7'h3B: err = (xlen != 64);
      7'h73: if (zic && i[14]) begin fmt = 3'd6; v = longint'(i[19:15]); end
      default: err = 1'b1;
    endcase
    imm = (xlen == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v);
  endfunction

  task automatic check_out();
    logic [63:0] eimm; logic [2:0] efmt; logic eerr;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("valid%0d", k), 64'(o_vld[k]), 64'(q.size() != 0));
      chk($sformatf("ready%0d", k), 64'(o_rdy[k]), 64'(q.size() < 2));
      if (q.size() != 0) begin
        ref_dec(q[0].inst, xl[k], zc[k], eimm, efmt, eerr);
        chk($sformatf("imm%0d", k), o_imm[k], eimm);
        chk($sformatf("fmt%0d", k), 64'(o_fmt[k]), 64'(efmt));
        chk($sformatf("err%0d", k), 64'(o_err[k]), 64'(eerr));
        chk($sformatf("inst%0d", k), 64'(o_inst[k]), 64'(q[0].inst));
        chk($sformatf("tag%0d", k), 64'(o_tag[k]), 64'(q[0].tag));
      end
    end
  endtask

  // One clock: handshakes are decided from the model's occupancy before the
  // edge, the scoreboard is updated after it and outputs compared at edge+1.
  task automatic step();
    bit fire_in, fire_out, fl;
    ent_t e;
    fire_in  = in_valid && (q.size() < 2);
    fire_out = out_ready && (q.size() != 0);
    fl       = flush;
    e.inst   = in_inst;
    e.tag    = in_tag;
    @(posedge clk);
    #1;
    last_acc = fire_in && !fl;
    if (fl) q.delete();
    else begin
      if (fire_out) void'(q.pop_front());
      if (fire_in) q.push_back(e);
    end
    check_out();
  endtask

  task automatic put(input logic [31:0] inst);
    in_valid = 1'b1; in_inst = inst; in_tag = tagctr; tagctr++;
    step();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 13)];
    return r;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", 64'(o_vld[k]), 64'd0);
      chk("rst_ready", 64'(o_rdy[k]), 64'd1);
      chk("rst_err", 64'(o_err[k]), 64'd0);
      chk("rst_fmt", 64'(o_fmt[k]), 64'd0);
      chk("rst_imm", o_imm[k], 64'd0);
    end
    rst = 1'b0;

    // Directed decodes with literal expectations.
    put(32'hFFF00093); chk("addi_imm", o_imm[0], 64'hFFFF_FFFF); chk("addi_fmt", 64'(o_fmt[0]), 64'd1);
    put(32'hFE112E23); chk("sw_imm", o_imm[0], 64'hFFFF_FFFC); chk("sw_fmt", 64'(o_fmt[0]), 64'd2);
    put(32'hFE000CE3); chk("beq_imm", o_imm[0], 64'hFFFF_FFF8); chk("beq_fmt", 64'(o_fmt[0]), 64'd3);
    put(32'h123450B7); chk("lui_imm", o_imm[0], 64'h1234_5000); chk("lui_fmt", 64'(o_fmt[0]), 64'd4);
    put(32'h800000B7); chk("lui64_imm", o_imm[1], 64'hFFFF_FFFF_8000_0000);
    put(32'h3002D073); chk("csr_fmt", 64'(o_fmt[1]), 64'd6); chk("csr_imm", o_imm[1], 64'd5);
    chk("nozicsr_fmt", 64'(o_fmt[2]), 64'd0); chk("nozicsr_err", 64'(o_err[2]), 64'd0);
    put(32'h00000000); chk("ill0_err", 64'(o_err[0]), 64'd1); chk("ill0_imm", o_imm[0], 64'd0);
    put(32'h0000007F); chk("ill7f_err", 64'(o_err[0]), 64'd1); chk("ill7f_fmt", 64'(o_fmt[0]), 64'd0);
    in_valid = 1'b0; step();

    // Back-pressure: A in M, B in K, C held until the stall releases.
    out_ready = 1'b0;
    put(32'h00100093);
    put(32'h00200113);
    chk("bp_ready", 64'(o_rdy[0]), 64'd0);
    chk("bp_head", 64'(o_inst[0]), 64'h0010_0093);
    put(32'h00300193);
    step();
    chk("bp_hold", 64'(o_inst[0]), 64'h0010_0093);
    out_ready = 1'b1;
    step(); chk("bp_second", 64'(o_inst[0]), 64'h0020_0113);
    step(); chk("bp_third", 64'(o_inst[0]), 64'h0030_0193);
    in_valid = 1'b0; step();

    // Flush with both entries full and a concurrent offer.
    out_ready = 1'b0;
    put(32'h00400213);
    put(32'h00500293);
    flush = 1'b1; in_inst = 32'h00600313; in_tag = tagctr;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(vld_a), 64'd0);
    chk("flush_ready", 64'(rdy_a), 64'd1);
    out_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    put(32'h00700393);
    put(32'h00800413);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("arst_valid", 64'(o_vld[k]), 64'd0);
      chk("arst_ready", 64'(o_rdy[k]), 64'd1);
    end
    q.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    // Randomized traffic; a rejected offer is held unchanged.
    in_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_inst  = rand_inst();
        in_tag   = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. It accepts one instruction word per cycle over a valid/ready handshake and extracts and sign-extends the immediate to XLEN. It also classifies the immediate format and flags unrecognised encodings. A 2-entry skid buffer keeps full throughput under back-pressure from execute. It replaces the single-cycle combinational generator and adds RV64, Zicsr zimm and illegal-encoding detection.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- EN_ZICSR, 1, 1 = decode SYSTEM CSR-immediate forms as format Z; 0 = treat SYSTEM as format N.
- TAG_W, 32, width of the sideband tag (PC) carried alongside each instruction.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards both buffered entries.
- in_valid  in  1  upstream holds an instruction.
- in_ready  out  1  block can accept an instruction this cycle.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output entry is valid.
- out_ready  in  1  downstream accepts the output this cycle.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format code: 0=N, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z; 7 is never produced.
- out_err  out  1  unrecognised encoding.
- out_inst  out  32  instruction word, passed through.
- out_tag  out  TAG_W  tag, passed through.

## Operation
- Decoding is combinational on in_inst; the result is captured on acceptance (in_valid && in_ready).
- Opcode map:
  - 0000011, 0010011, 1100111 → I. If XLEN=64, 0011011 is also I.
  - 0100011 → S; 1100011 → B; 0010111, 0110111 → U; 1101111 → J.
- Known opcodes that produce format N with imm 0 and err 0:
  - 0110011, 0001111.
  - 0111011 when XLEN=64.
  - 1110011, except the case below.
- 1110011 with EN_ZICSR=1 and inst[14]=1 → Z, imm = zero-extended inst[19:15].
- Any other opcode, or inst[1:0] != 2'b11 → N, imm 0, err 1.
- Immediate construction:
  - I = inst[31:20].
  - S = {inst[31:25], inst[11:7]}.
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U = {inst[31:12], 12'b0}.
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - I/S/B/U/J are sign-extended from their MSB to XLEN. U with XLEN=64 is sign-extended from bit 31.
- Buffering: main register M (drives outputs) plus skid register K.
  - in_ready = !K.valid. It is registered, so it depends only on state, never combinationally on out_ready.
  - M empty, or M consumed this cycle:
    - K valid → K moves to M.
    - Else, on acceptance → the new entry loads M.
  - K valid and M consumed, with a simultaneous acceptance → K moves to M and the new entry loads K. This cannot occur, because in_ready=0 while K is valid.
  - M valid and not consumed, with acceptance → the new entry loads K.
  - Order is strictly preserved. There is no drop and no duplication.
- flush:
  - Clears M.valid and K.valid at the next edge.
  - Any acceptance in the same cycle is discarded.
  - flush has priority over all other updates.
- Data registers need no reset; only the valid bits are reset.

## Timing
- Reset values: out_valid=0, in_ready=1, out_err=0, out_fmt=0, out_imm=0.
- Latency: instruction accepted at edge n → out_valid=1 with its result after edge n; the result is visible in cycle n+1.
- Throughput: 1 instruction per cycle while out_ready=1.
- Stall: with out_ready=0, a second accepted instruction fills K and in_ready falls after that edge. Upstream must then hold its data.
- Restart: the first cycle out_ready=1 consumes M and moves K into M. in_ready returns to 1 after that edge.
- Output stability: out_* is stable while out_valid && !out_ready.
- rst asserted mid-stream: immediately clears both valid bits, regardless of clk.

## Test plan
- XLEN=32, in_inst=0xFFF00093 (addi) with out_ready=1 → next cycle out_imm=0xFFFFFFFF, fmt=1, err=0.
- Back-to-back stream:
  - 0xFE112E23 → imm 0xFFFFFFFC, fmt=2.
  - 0xFE000CE3 → imm 0xFFFFFFF8, fmt=3.
  - 0x123450B7 → imm 0x12345000, fmt=4.
  - Expect one result per cycle, in order.
- XLEN=64: 0x800000B7 → out_imm=0xFFFFFFFF80000000. 0x3002D073 → fmt=6, imm=5. With EN_ZICSR=0 the same word gives fmt=0, err=0.
- Illegal encodings: 0x00000000 and 0x0000007F → fmt=0, imm=0, err=1.
- Back-pressure sequence:
  1. Hold out_ready=0 and offer A, B, C.
  2. A is in M and B is in K; in_ready=0 after B is accepted; C is held.
  3. Raise out_ready → outputs appear as A, B, C on consecutive cycles.
- flush with M and K full plus a concurrent in_valid → next cycle out_valid=0 and in_ready=1, and no discarded entry ever appears.
- rst pulse mid-stall → out_valid=0 and in_ready=1 immediately.
